// File: rtl/ppf_pkg.sv
// ppf_pkg: shared definitions for the polyphase filter-bank commutator.
//   ppf_state_e   : sequencer state encoding
//   ppf_marker_t  : frame marker bundle {valid, sop, eop, good}
//   clogb2        : bits needed to index n items (minimum 1)
//   flush_frames  : number of whole zero frames injected at end of stream
package ppf_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_RUN   = 2'd2,
        ST_FLUSH = 2'd3
    } ppf_state_e;

    typedef struct packed {
        logic valid;
        logic sop;
        logic eop;
        logic good;
    } ppf_marker_t;

    function automatic int clogb2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        if (r == 0) r = 1;
        return r;
    endfunction

    // Every branch needs TAPS-1 older samples pushed through before the
    // last real sample reaches the end of its delay line.
    function automatic int flush_frames(input int taps);
        return taps - 1;
    endfunction

endpackage

// File: rtl/ppf_marker_delay.sv
// ppf_marker_delay: fixed-depth shift register for frame markers, aligning
// them with the branch-filter output latency.
//   clk_i  : clock
//   rst_i  : synchronous active-high clear of every stage
//   d_i    : marker entering the pipe
//   q_o    : marker delayed by DEPTH cycles
module ppf_marker_delay
    import ppf_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  ppf_marker_t d_i,
    output ppf_marker_t q_o
);

    ppf_marker_t pipe_q [DEPTH];
    ppf_marker_t pipe_d [DEPTH];

    always_comb begin
        pipe_d[0] = d_i;
        for (int i = 1; i < DEPTH; i++) pipe_d[i] = pipe_q[i-1];
    end

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (rst_i) pipe_q[i] <= '0;
            else       pipe_q[i] <= pipe_d[i];
        end
    end

    assign q_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/ppf_commutator_ctrl.sv
// ppf_commutator_ctrl: front-end sequencer for the polyphase filter bank.
// Accepts a complex sample stream (valid/ready), commutates it round-robin
// onto NUM_BRANCH branch filters starting at branch NUM_BRANCH-1, and emits
// latency-aligned frame markers for the downstream FFT. Tracks warm-up and
// end-of-stream zero flush so only fully-primed frames are flagged good.
//
// Ports:
//   clk_i, rst_i            : clock, synchronous active-high reset
//   s_valid_i / s_ready_o   : input handshake
//   s_real_i / s_imag_i     : input sample
//   flush_i                 : end-of-stream request (FILL/RUN only)
//   br_valid_o              : one-hot branch write strobe
//   br_real_o / br_imag_o   : registered sample broadcast to all branches
//   frm_valid/sop/eop/good_o: frame markers delayed by FILT_LATENCY
//   busy_o                  : sequencer not idle
//   ovr_cnt_o               : refused-sample counter, only when
//                             PPF_COMMUTATOR_OVERRUN_CNT_EN is defined
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | waiting for the first sample of a stream
// ST_FILL  | accepting samples, branch delay lines not yet primed
// ST_RUN   | accepting samples, output frames are good
// ST_FLUSH | input blocked, injecting zeros to drain the delay lines
module ppf_commutator_ctrl
    import ppf_pkg::*;
#(
    parameter int NUM_BRANCH      = 8,
    parameter int TAPS_PER_BRANCH = 4,
    parameter int DIN_WIDTH       = 16,
    parameter int FILT_LATENCY    = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  s_valid_i,
    output logic                  s_ready_o,
    input  logic [DIN_WIDTH-1:0]  s_real_i,
    input  logic [DIN_WIDTH-1:0]  s_imag_i,
    input  logic                  flush_i,
    output logic [NUM_BRANCH-1:0] br_valid_o,
    output logic [DIN_WIDTH-1:0]  br_real_o,
    output logic [DIN_WIDTH-1:0]  br_imag_o,
    output logic                  frm_valid_o,
    output logic                  frm_sop_o,
    output logic                  frm_eop_o,
    output logic                  frm_good_o,
    output logic                  busy_o
`ifdef PPF_COMMUTATOR_OVERRUN_CNT_EN
    ,
    output logic [15:0]           ovr_cnt_o
`endif
);

    localparam int BW           = clogb2(NUM_BRANCH);
    localparam int FW           = clogb2(TAPS_PER_BRANCH + 1);
    localparam int FLUSH_FRAMES = flush_frames(TAPS_PER_BRANCH);
    localparam logic [BW-1:0] BR_LAST = BW'(NUM_BRANCH - 1);
    localparam logic [FW-1:0] TAPS_C  = FW'(TAPS_PER_BRANCH);
    localparam logic [FW-1:0] FLUSH_C = FW'(FLUSH_FRAMES);

    ppf_state_e            state_q, state_d;
    logic [BW-1:0]         br_cnt_q, br_cnt_d;
    logic [FW-1:0]         frm_cnt_q, frm_cnt_d;
    logic [FW-1:0]         flush_cnt_q, flush_cnt_d;
    logic                  s_ready_q, s_ready_d;
    logic                  busy_q, busy_d;
    logic [NUM_BRANCH-1:0] br_valid_q, br_valid_d;
    logic [DIN_WIDTH-1:0]  br_real_q, br_real_d;
    logic [DIN_WIDTH-1:0]  br_imag_q, br_imag_d;
    ppf_marker_t           tag_q, tag_d;
    ppf_marker_t           mk_dly;

    logic accept, inject, strobe, frame_end;

    assign accept    = s_valid_i & s_ready_q;
    // flush_cnt_q counts frame ends still owed; zero means nothing to inject
    assign inject    = (state_q == ST_FLUSH) && (flush_cnt_q != '0);
    assign strobe    = accept | inject;
    assign frame_end = strobe && (br_cnt_q == '0);

    always_comb begin
        state_d     = state_q;
        br_cnt_d    = br_cnt_q;
        frm_cnt_d   = frm_cnt_q;
        flush_cnt_d = flush_cnt_q;
        br_valid_d  = '0;
        br_real_d   = br_real_q;
        br_imag_d   = br_imag_q;
        tag_d       = '0;

        if (strobe) begin
            br_valid_d[br_cnt_q] = 1'b1;
            br_real_d  = inject ? '0 : s_real_i;
            br_imag_d  = inject ? '0 : s_imag_i;
            tag_d.valid = 1'b1;
            tag_d.sop   = (br_cnt_q == BR_LAST);
            tag_d.eop   = (br_cnt_q == '0);
            tag_d.good  = (state_q == ST_RUN) || (state_q == ST_FLUSH);
            br_cnt_d    = (br_cnt_q == '0) ? BR_LAST : br_cnt_q - BW'(1);
        end

        case (state_q)
            ST_IDLE: begin
                frm_cnt_d   = '0;
                flush_cnt_d = '0;
                if (accept) state_d = ST_FILL;
            end
            ST_FILL, ST_RUN: begin
                if (frame_end && frm_cnt_q != TAPS_C) frm_cnt_d = frm_cnt_q + FW'(1);
                if (flush_i) begin
                    state_d = ST_FLUSH;
                    // one extra frame end when the stream stopped mid-frame
                    flush_cnt_d = FLUSH_C + FW'(br_cnt_d != BR_LAST);
                end else if (frm_cnt_d == TAPS_C) begin
                    state_d = ST_RUN;
                end
            end
            ST_FLUSH: begin
                if (flush_cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else if (frame_end) begin
                    flush_cnt_d = flush_cnt_q - FW'(1);
                    if (flush_cnt_q == FW'(1)) state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        s_ready_d = (state_d != ST_FLUSH);
        busy_d    = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            br_cnt_q    <= BR_LAST;
            frm_cnt_q   <= '0;
            flush_cnt_q <= '0;
            s_ready_q   <= 1'b0;
            busy_q      <= 1'b0;
            br_valid_q  <= '0;
            br_real_q   <= '0;
            br_imag_q   <= '0;
            tag_q       <= '0;
        end else begin
            state_q     <= state_d;
            br_cnt_q    <= br_cnt_d;
            frm_cnt_q   <= frm_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            s_ready_q   <= s_ready_d;
            busy_q      <= busy_d;
            br_valid_q  <= br_valid_d;
            br_real_q   <= br_real_d;
            br_imag_q   <= br_imag_d;
            tag_q       <= tag_d;
        end
    end

    ppf_marker_delay #(
        .DEPTH (FILT_LATENCY)
    ) u_marker_delay (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (tag_q),
        .q_o   (mk_dly)
    );

`ifdef PPF_COMMUTATOR_OVERRUN_CNT_EN
    logic [15:0] ovr_cnt_q, ovr_cnt_d;

    always_comb begin
        ovr_cnt_d = ovr_cnt_q;
        if (s_valid_i && !s_ready_q && state_q == ST_FLUSH && ovr_cnt_q != 16'hFFFF)
            ovr_cnt_d = ovr_cnt_q + 16'd1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) ovr_cnt_q <= '0;
        else       ovr_cnt_q <= ovr_cnt_d;
    end

    assign ovr_cnt_o = ovr_cnt_q;
`endif

    assign s_ready_o   = s_ready_q;
    assign busy_o      = busy_q;
    assign br_valid_o  = br_valid_q;
    assign br_real_o   = br_real_q;
    assign br_imag_o   = br_imag_q;
    assign frm_valid_o = mk_dly.valid;
    assign frm_sop_o   = mk_dly.sop;
    assign frm_eop_o   = mk_dly.eop;
    assign frm_good_o  = mk_dly.good;

endmodule
